// File: rtl/itype_inst_encoder_pkg.sv
// Shared types and helpers for the I-type instruction encoder.
//   inst_type_e     : supported I-type major opcodes
//   i_type_t        : I-type field bundle, packed in instruction bit order
//   is_legal_itype  : legality check for a field bundle
package itype_inst_encoder_pkg;

  typedef enum logic [6:0] {
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    JALR   = 7'b1100111
  } inst_type_e;

  // Field order matches the instruction word, so a cast yields the encoding.
  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  localparam logic [2:0] F3_LB        = 3'b000;
  localparam logic [2:0] F3_LH        = 3'b001;
  localparam logic [2:0] F3_LW        = 3'b010;
  localparam logic [2:0] F3_LBU       = 3'b100;
  localparam logic [2:0] F3_LHU       = 3'b101;
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
  localparam logic [2:0] F3_JALR      = 3'b000;

  localparam logic [6:0] FUNCT7_SRLI = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRAI = 7'b0100000;

  function automatic logic is_legal_itype(i_type_t inst);
    logic       legal;
    logic [6:0] funct7;
    funct7 = inst.imm[11:5];
    legal  = 1'b0;
    case (inst.opcode)
      OP_IMM: begin
        // Shift immediates reuse imm[11:5] as funct7.
        if (inst.func3 == F3_SLLI) begin
          legal = (funct7 == FUNCT7_SRLI);
        end else if (inst.func3 == F3_SRLI_SRAI) begin
          legal = (funct7 == FUNCT7_SRLI) || (funct7 == FUNCT7_SRAI);
        end else begin
          legal = 1'b1;
        end
      end
      LOAD:    legal = inst.func3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      JALR:    legal = (inst.func3 == F3_JALR);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/itype_inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream.
//   in_*  : valid/ready bundle stream (master drives valid + fields)
//   out_* : valid/ready instruction stream (slave drives valid + inst)
interface itype_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [4:0]  in_rs1;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;

  modport master (
    output in_valid, in_opcode, in_rd, in_func3, in_rs1, in_imm, out_ready,
    input  in_ready, out_valid, out_inst
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_func3, in_rs1, in_imm, out_ready,
    output in_ready, out_valid, out_inst
  );
endinterface

// File: rtl/inst_fifo2.sv
// 2-entry, 32-bit synchronous FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (caller ensures count < 2 unless popping)
//   pop      : drop head (caller ensures count != 0)
//   rdata    : head entry, straight from a register
//   count    : occupancy 0..2
module inst_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  count
);

  logic [31:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = wdata;
        else                 tail_d = wdata;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; head advances to the next word in order.
        if (count_q == 2'd1) begin
          head_d = wdata;
        end else begin
          head_d = tail_q;
          tail_d = wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rdata = head_q;
  assign count = count_q;

endmodule

// File: rtl/itype_inst_encoder.sv
// Streaming I-type instruction encoder.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : bundle input / encoded word output streams
//   illegal       : registered one-cycle pulse after a rejected bundle
//   inst_count    : words taken by the consumer (wraps)
//   illegal_count : rejected bundles (saturates)
module itype_inst_encoder
  import itype_inst_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ILL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  itype_inst_encoder_if.slave bus,
  output logic               illegal,
  output logic [CNT_W-1:0]   inst_count,
  output logic [ILL_W-1:0]   illegal_count
);

  i_type_t    bundle;
  logic       accept, legal, push, pop, reject;
  logic [1:0] fifo_count;
  logic       illegal_q;
  logic [CNT_W-1:0] inst_count_q;
  logic [ILL_W-1:0] illegal_count_q;

  assign bundle = '{imm: bus.in_imm, rs1: bus.in_rs1, func3: bus.in_func3,
                    rd: bus.in_rd, opcode: bus.in_opcode};
  assign legal  = is_legal_itype(bundle);

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (fifo_count != 2'd2);
  assign bus.out_valid = (fifo_count != 2'd0);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign reject = accept && !legal;
  assign pop    = bus.out_valid && bus.out_ready;

  inst_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bundle),
    .rdata (bus.out_inst),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q       <= 1'b0;
      inst_count_q    <= '0;
      illegal_count_q <= '0;
    end else begin
      illegal_q <= reject;
      if (pop) inst_count_q <= inst_count_q + 1'b1;
      if (reject && (illegal_count_q != {ILL_W{1'b1}})) begin
        illegal_count_q <= illegal_count_q + 1'b1;
      end
    end
  end

  assign illegal       = illegal_q;
  assign inst_count    = inst_count_q;
  assign illegal_count = illegal_count_q;

endmodule
